// File: rtl/pc_unit.sv
// Fetch-stage program counter with a BOOT/RUN/HALT sequencer and a circular return-address stack.
// Optional feature: define PC_MISALIGN_TRAP_EN to trap misaligned redirect targets to EXC_VECTOR.
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [31:0]      EXC_VECTOR   = 32'h0000_0180,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             stall,
  input  logic             halt,
  input  logic             exc,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             call,
  input  logic             ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             fetch_valid,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             misalign
);

  localparam int unsigned      PW         = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] EXC_PC     = WIDTH'(EXC_VECTOR);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
  localparam logic [PW:0]      CNT_FULL   = (PW+1)'(RAS_DEPTH);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    sp_q, sp_d;
  logic [PW:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];

  logic [WIDTH-1:0] sel_tgt;
  logic             redirect, trap, ras_en, push, pop, repl, wr_en;
  logic [PW-1:0]    wr_idx;

  assign pc          = pc_q;
  assign pc_plus4    = pc_q + WIDTH'(4);
  assign fetch_valid = (state_q == ST_RUN);
  assign ras_empty   = (cnt_q == '0);
  assign ras_full    = (cnt_q == CNT_FULL);
  assign ras_top     = ras_empty ? '0 : ras_q[sp_q];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    trap     = 1'b0;
    redirect = jr | jump | br_taken;
    sel_tgt  = jr ? jr_target : (jump ? jump_target : br_target);
    unique case (state_q)
      ST_BOOT: state_d = ST_RUN;
      ST_RUN: begin
        // exc redirects even under stall; halt outranks any same-cycle redirect
        if (exc) begin
          pc_d = EXC_PC;
        end else if (!stall) begin
          if (halt) begin
            state_d = ST_HALT;
          end else if (redirect) begin
`ifdef PC_MISALIGN_TRAP_EN
            if (|sel_tgt[1:0]) begin
              pc_d = EXC_PC;
              trap = 1'b1;
            end else begin
              pc_d = sel_tgt;
            end
`else
            pc_d = sel_tgt & ALIGN_MASK;
`endif
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      ST_HALT: begin
        if (exc) begin
          pc_d    = EXC_PC;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_BOOT;
    endcase
  end

  always_comb begin
    ras_en = (state_q == ST_RUN) && !stall && !exc && !trap;
    push   = ras_en && call && !ret;
    pop    = ras_en && ret && !call && !ras_empty;
    repl   = ras_en && call && ret;
    sp_d   = sp_q;
    cnt_d  = cnt_q;
    if (push) begin
      sp_d  = sp_q + PW'(1);
      cnt_d = ras_full ? cnt_q : cnt_q + (PW+1)'(1);
    end else if (pop) begin
      sp_d  = sp_q - PW'(1);
      cnt_d = cnt_q - (PW+1)'(1);
    end
    // a push on a full stack lands on the oldest slot, overwriting it
    wr_en  = push || repl;
    wr_idx = push ? sp_q + PW'(1) : sp_q;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VECTOR;
      sp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) ras_q[wr_idx] <= pc_plus4;
  end

`ifdef PC_MISALIGN_TRAP_EN
  logic misalign_q;
  always_ff @(posedge clk or posedge clr) begin
    if (clr) misalign_q <= 1'b0;
    else     misalign_q <= trap;
  end
  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios then randomized traffic against a behavioural model.
module tb_pc_unit;

  localparam int unsigned D = 4;
  localparam logic [31:0] EXC = 32'h0000_0180;
`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        clr, stall, halt, exc, jr, jump, br_taken, call, ret;
  logic [31:0] jr_target, jump_target, br_target;
  logic [31:0] pc, pc_plus4, ras_top;
  logic        fetch_valid, ras_empty, ras_full, misalign;

  int checks   = 0;
  int failures = 0;

  // reference model state
  logic [31:0] m_pc;
  bit          m_booted, m_halted, m_mis;
  logic [31:0] m_ras [$];

  pc_unit #(.WIDTH(32), .RESET_VECTOR(32'h0), .EXC_VECTOR(EXC), .RAS_DEPTH(D)) dut (
    .clk(clk), .clr(clr), .stall(stall), .halt(halt), .exc(exc),
    .jr(jr), .jr_target(jr_target), .jump(jump), .jump_target(jump_target),
    .br_taken(br_taken), .br_target(br_target), .call(call), .ret(ret),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_valid(fetch_valid), .ras_top(ras_top),
    .ras_empty(ras_empty), .ras_full(ras_full), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".pc_plus4"}, pc_plus4, m_pc + 32'd4);
    chk({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, m_booted && !m_halted});
    chk({tag, ".ras_top"}, ras_top, (m_ras.size() == 0) ? 32'd0 : m_ras[$]);
    chk({tag, ".ras_empty"}, {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
    chk({tag, ".ras_full"}, {31'd0, ras_full}, {31'd0, m_ras.size() == D});
    chk({tag, ".misalign"}, {31'd0, misalign}, {31'd0, m_mis});
  endtask

  task automatic idle();
    stall = 0; halt = 0; exc = 0; jr = 0; jump = 0; br_taken = 0; call = 0; ret = 0;
  endtask

  // Advance the model by one clock using the currently driven inputs.
  task automatic mdl_next();
    logic [31:0] pc4, t;
    bit ras_ok, mis;
    pc4 = m_pc + 32'd4;
    ras_ok = 0;
    mis = 0;
    if (!m_booted) begin
      m_booted = 1;
    end else if (m_halted) begin
      if (exc) begin m_pc = EXC; m_halted = 0; end
    end else begin
      ras_ok = !stall && !exc;
      if (exc) m_pc = EXC;
      else if (!stall) begin
        if (halt) m_halted = 1;
        else if (jr || jump || br_taken) begin
          t = jr ? jr_target : (jump ? jump_target : br_target);
          if (TRAP && (t % 4 != 0)) begin m_pc = EXC; mis = 1; ras_ok = 0; end
          else m_pc = t - (t % 4);
        end else m_pc = pc4;
      end
      if (ras_ok) begin
        if (call && !ret) begin
          m_ras.push_back(pc4);
          if (m_ras.size() > D) void'(m_ras.pop_front());
        end else if (ret && !call) begin
          if (m_ras.size() > 0) void'(m_ras.pop_back());
        end else if (call && ret) begin
          if (m_ras.size() > 0) m_ras[m_ras.size()-1] = pc4;
        end
      end
    end
    m_mis = mis;
  endtask

  task automatic step(input string tag);
    mdl_next();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    #2 clr = 1;
    #1;
    m_pc = 32'h0; m_booted = 0; m_halted = 0; m_mis = 0;
    m_ras.delete();
    check_all(tag);
    #1 clr = 0;
  endtask

  logic [31:0] exp_ret [4] = '{32'h54, 32'h44, 32'h34, 32'h24};

  initial begin
    clr = 0;
    jr_target = '0; jump_target = '0; br_target = '0;
    idle();
    do_reset("reset");
    step("boot");
    chk("boot_fv", {31'd0, fetch_valid}, 32'd1);
    chk("boot_pc", pc, 32'h0);
    step("seq1"); step("seq2"); step("seq3");
    chk("seq_pc", pc, 32'hc);

    // clr mid-run: pc returns to 0 asynchronously, then 0,4,8
    do_reset("clr_mid");
    chk("clr_pc", pc, 32'h0);
    step("clr_boot"); step("clr_s1"); step("clr_s2");
    chk("clr_seq", pc, 32'h8);

    // priority among simultaneous redirects
    jr = 1; jump = 1; br_taken = 1;
    jr_target = 32'h40; jump_target = 32'h80; br_target = 32'hc0;
    step("prio");
    chk("prio_pc", pc, 32'h40);
    idle();
    stall = 1; br_taken = 1; step("stall_br");
    chk("stall_br_pc", pc, 32'h40);
    exc = 1; step("stall_exc");
    chk("stall_exc_pc", pc, EXC);

    // RAS: five calls at 0x10..0x50 overflow the four-entry stack
    idle(); jump = 1; jump_target = 32'h10; step("ras_j");
    for (int i = 0; i < 5; i++) begin
      call = 1; jump = 1; jump_target = 32'h20 + 32'h10 * i;
      step("ras_call");
    end
    idle();
    chk("ras_full_c", {31'd0, ras_full}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("ras_ret_top", ras_top, exp_ret[i]);
      ret = 1; step("ras_ret");
    end
    chk("ras_empty_c", {31'd0, ras_empty}, 32'd1);
    step("ras_ret5");
    chk("ras_top_empty", ras_top, 32'h0);
    idle();
    call = 1; step("ras_push1");
    call = 1; ret = 1; step("ras_repl");
    idle();

    // halt and exception-only exit
    jump = 1; jump_target = 32'h20; step("h_j");
    idle(); halt = 1; step("halt");
    chk("halt_pc", pc, 32'h20);
    chk("halt_fv", {31'd0, fetch_valid}, 32'd0);
    halt = 0; jump = 1; jump_target = 32'h400; step("halt_hold1");
    idle(); step("halt_hold2");
    exc = 1; step("halt_exc");
    chk("halt_exit_pc", pc, EXC);
    chk("halt_exit_fv", {31'd0, fetch_valid}, 32'd1);

    // misaligned jump target
    idle(); jump = 1; jump_target = 32'h42; step("mis");
    chk("mis_pc", pc, TRAP ? EXC : 32'h40);
    chk("mis_flag", {31'd0, misalign}, TRAP ? 32'd1 : 32'd0);
    idle(); step("mis_after");
    chk("mis_clear", {31'd0, misalign}, 32'd0);

    // pc_plus4 wrap
    jump = 1; jump_target = 32'hffff_fffc; step("wrap_j");
    chk("wrap_p4", pc_plus4, 32'h0);
    idle(); step("wrap");
    chk("wrap_pc", pc, 32'h0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(79) == 0) begin
        idle();
        do_reset("rnd_clr");
      end
      stall    = ($urandom_range(3) == 0);
      halt     = ($urandom_range(40) == 0);
      exc      = ($urandom_range(15) == 0);
      jr       = ($urandom_range(7) == 0);
      jump     = ($urandom_range(7) == 0);
      br_taken = ($urandom_range(5) == 0);
      call     = ($urandom_range(3) == 0);
      ret      = ($urandom_range(3) == 0);
      jr_target   = $urandom;
      jump_target = $urandom;
      br_target   = $urandom;
      step("rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
